// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch queue with redirect flush; FETCH_BYPASS_EN enables the empty-FIFO bypass path
module instr_fetch_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_bus,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_d [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_d   [DEPTH];

  logic [CNT_W:0] occupancy;
  logic           fifo_valid;
  logic           bypass_valid;
  logic           issue;
  logic           capture;
  logic           bypass_take;
  logic           write_en;
  logic           pop_fifo;

  assign i_addr = fetch_pc_q;

  // Control decode: occupancy counts buffered plus in-flight words so a capture never meets a full FIFO
  always_comb begin
    occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    fifo_valid = (count_q != '0);
`ifdef FETCH_BYPASS_EN
    bypass_valid = !fifo_valid && inflight_q && !redirect;
`else
    bypass_valid = 1'b0;
`endif
    issue       = !redirect && (occupancy < DEPTH_OCC);
    capture     = inflight_q && !redirect;
    bypass_take = bypass_valid && instr_ready;
    write_en    = capture && !bypass_take;
    pop_fifo    = fifo_valid && instr_ready && !redirect;
  end

  // Decode-side outputs: FIFO head first, bypassed memory word when empty, zeros when idle
  always_comb begin
    instr_valid = fifo_valid || bypass_valid;
    instr       = '0;
    instr_pc    = '0;
    if (fifo_valid) begin
      instr    = fifo_data_q[rd_ptr_q];
      instr_pc = fifo_pc_q[rd_ptr_q];
    end else if (bypass_valid) begin
      instr    = i_bus;
      instr_pc = inflight_pc_q;
    end
  end

  // Next state for fetch PC, in-flight tracking, pointers, count and FIFO storage
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_data_d   = fifo_data_q;
    fifo_pc_d     = fifo_pc_q;

    if (redirect) begin
      // Squash everything buffered and the word still in the memory pipeline
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 1'b1;
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end else begin
        inflight_d = 1'b0;
      end

      if (write_en) begin
        fifo_data_d[wr_ptr_q] = i_bus;
        fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
        wr_ptr_d              = wr_ptr_q + 1'b1;
      end

      if (pop_fifo) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({write_en, pop_fifo})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // FIFO storage is never read while count is zero, so it carries no reset
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_pc_q   <= fifo_pc_d;
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue with a sequential-PC reference model
module tb_instr_fetch_queue;

  localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] i_addr;
  logic [15:0] i_bus;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] exp_pc;
  logic        obs_valid;
  logic [15:0] obs_instr;
  logic [15:0] obs_pc;

  instr_fetch_queue #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .DEPTH   (4),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_addr     (i_addr),
    .i_bus      (i_bus),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // One-cycle registered instruction memory
  always @(posedge clk) i_bus <= mem[i_addr];

  task automatic drive(input logic rdy, input logic redir, input logic [15:0] rpc);
    @(negedge clk);
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    obs_valid = instr_valid;
    obs_instr = instr;
    obs_pc    = instr_pc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic preload_seq();
    for (int i = 0; i < 8; i++) mem[i] = 16'hA000 + 16'(i);
  endtask

  task automatic run_first_scenario(input string tag);
    int first = -1;
    int n = 0;
    for (int cyc = 1; cyc <= 20 && n < 8; cyc++) begin
      drive(1'b1, 1'b0, 16'h0000);
      if (obs_valid && first < 0) first = cyc;
      if (first >= 0) begin
        checks++;
        if (!obs_valid) begin
          errors++;
          $display("FAIL %s_throughput: cycle %0d valid=%b, expected 1", tag, cyc, obs_valid);
        end
      end
      if (obs_valid) begin
        checks++;
        if (obs_pc !== 16'(n) || obs_instr !== 16'hA000 + 16'(n)) begin
          errors++;
          $display("FAIL %s_word: pc=%h instr=%h, expected pc=%h instr=%h",
                   tag, obs_pc, obs_instr, 16'(n), 16'hA000 + 16'(n));
        end
        n++;
      end
    end
    exp_pc = 16'(n);
    checks++;
    if (first != LAT) begin
      errors++;
      $display("FAIL %s_latency: first valid at cycle %0d, expected %0d", tag, first, LAT);
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL %s_count: %0d words, expected 8", tag, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pc !== 16'h0000 || i_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_state: valid=%b instr=%h pc=%h addr=%h, expected 0 0000 0000 %h",
               instr_valid, instr, instr_pc, i_addr, RESET_PC);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    preload_seq();
    do_reset();
    rst_n = 1'b1;
    run_first_scenario("stream");
  endtask

  task automatic test_stall();
    int n = 0;
    preload_seq();
    do_reset();
    rst_n  = 1'b1;
    exp_pc = RESET_PC;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      drive(1'b0, 1'b0, 16'h0000);
      if (cyc >= 4) begin
        checks++;
        if (i_addr !== RESET_PC + 16'd4) begin
          errors++;
          $display("FAIL stall_addr: cycle %0d addr=%h, expected %h", cyc, i_addr, RESET_PC + 16'd4);
        end
      end
    end
    checks++;
    if (obs_valid !== 1'b1 || obs_instr !== 16'hA000) begin
      errors++;
      $display("FAIL stall_head: valid=%b instr=%h, expected 1 a000", obs_valid, obs_instr);
    end
    for (int cyc = 0; cyc < 30 && n < 12; cyc++) begin
      drive(1'b1, 1'b0, 16'h0000);
      if (obs_valid) begin
        checks++;
        if (obs_pc !== exp_pc || obs_instr !== mem[exp_pc]) begin
          errors++;
          $display("FAIL stall_word: pc=%h instr=%h, expected pc=%h instr=%h",
                   obs_pc, obs_instr, exp_pc, mem[exp_pc]);
        end
        exp_pc++;
        n++;
      end
    end
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL stall_count: %0d words, expected 12", n);
    end
  endtask

  task automatic test_redirect_inflight();
    int n = 0;
    mem[16'h0020] = 16'h1234;
    preload_seq();
    do_reset();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) drive(1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, 16'h0020);
    drive(1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs_valid !== 1'b0 || i_addr !== 16'h0020) begin
      errors++;
      $display("FAIL redir_flush: valid=%b addr=%h, expected 0 0020", obs_valid, i_addr);
    end
    exp_pc = 16'h0020;
    for (int cyc = 0; cyc < 20 && n < 5; cyc++) begin
      drive(1'b1, 1'b0, 16'h0000);
      if (obs_valid) begin
        checks++;
        if (n == 0 && (obs_pc !== 16'h0020 || obs_instr !== 16'h1234)) begin
          errors++;
          $display("FAIL redir_first: pc=%h instr=%h, expected pc=0020 instr=1234", obs_pc, obs_instr);
        end else if (obs_pc !== exp_pc || obs_instr !== mem[exp_pc]) begin
          errors++;
          $display("FAIL redir_word: pc=%h instr=%h, expected pc=%h instr=%h",
                   obs_pc, obs_instr, exp_pc, mem[exp_pc]);
        end
        exp_pc++;
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL redir_count: %0d words, expected 5", n);
    end
  endtask

  task automatic test_redirect_pop();
    int n = 0;
    for (int cyc = 0; cyc < 3; cyc++) drive(1'b0, 1'b0, 16'h0000);
    drive(1'b1, 1'b1, 16'h0040);
    checks++;
    if (obs_valid !== 1'b1) begin
      errors++;
      $display("FAIL rpop_head: valid=%b, expected 1", obs_valid);
    end
    drive(1'b0, 1'b0, 16'h0000);
    checks++;
    if (obs_valid !== 1'b0 || i_addr !== 16'h0040) begin
      errors++;
      $display("FAIL rpop_flush: valid=%b addr=%h, expected 0 0040", obs_valid, i_addr);
    end
    exp_pc = 16'h0040;
    for (int cyc = 0; cyc < 20 && n < 6; cyc++) begin
      drive(1'b1, 1'b0, 16'h0000);
      if (obs_valid) begin
        checks++;
        if (obs_pc !== exp_pc || obs_instr !== mem[exp_pc]) begin
          errors++;
          $display("FAIL rpop_word: pc=%h instr=%h, expected pc=%h instr=%h",
                   obs_pc, obs_instr, exp_pc, mem[exp_pc]);
        end
        exp_pc++;
        n++;
      end
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL rpop_count: %0d words, expected 6", n);
    end
  endtask

  task automatic test_reset_midstream();
    preload_seq();
    for (int cyc = 0; cyc < 6; cyc++) drive(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n       = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0300;
    @(negedge clk);
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 16'h0000 || i_addr !== RESET_PC) begin
      errors++;
      $display("FAIL midreset_state: valid=%b instr=%h addr=%h, expected 0 0000 %h",
               instr_valid, instr, i_addr, RESET_PC);
    end
    redirect    = 1'b0;
    instr_ready = 1'b0;
    rst_n       = 1'b1;
    run_first_scenario("midreset");
  endtask

  task automatic test_wrap();
    logic [15:0] pcs  [3];
    logic [15:0] data [3];
    int n = 0;
    pcs[0] = 16'hFFFE; pcs[1] = 16'hFFFF; pcs[2] = 16'h0000;
    data[0] = 16'h0001; data[1] = 16'h0002; data[2] = 16'h0003;
    for (int i = 0; i < 3; i++) mem[pcs[i]] = data[i];
    drive(1'b1, 1'b1, 16'hFFFE);
    for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
      drive(1'b1, 1'b0, 16'h0000);
      if (obs_valid) begin
        checks++;
        if (obs_pc !== pcs[n] || obs_instr !== data[n]) begin
          errors++;
          $display("FAIL wrap_word: pc=%h instr=%h, expected pc=%h instr=%h",
                   obs_pc, obs_instr, pcs[n], data[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL wrap_count: %0d words, expected 3", n);
    end
    mem[16'h0000] = 16'hA000;
  endtask

  task automatic test_random();
    int   n = 0;
    logic rdy;
    logic redir = 1'b0;
    logic [15:0] rpc;
    do_reset();
    rst_n  = 1'b1;
    exp_pc = RESET_PC;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rdy   = ($urandom % 4) != 0;
      redir = redir ? (($urandom % 2) == 0) : (($urandom % 40) == 0);
      rpc   = 16'($urandom);
      drive(rdy, redir, rpc);
      if (!obs_valid) begin
        checks++;
        if (obs_instr !== 16'h0000) begin
          errors++;
          $display("FAIL rand_idle: instr=%h while invalid, expected 0000", obs_instr);
        end
      end
      if (redir) begin
        exp_pc = rpc;
      end else if (obs_valid && rdy) begin
        checks++;
        if (obs_pc !== exp_pc || obs_instr !== mem[exp_pc]) begin
          errors++;
          $display("FAIL rand_word: pc=%h instr=%h, expected pc=%h instr=%h",
                   obs_pc, obs_instr, exp_pc, mem[exp_pc]);
        end
        exp_pc++;
        n++;
      end
    end
    checks++;
    if (n < 200) begin
      errors++;
      $display("FAIL rand_progress: %0d words accepted, expected at least 200", n);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_pop();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
